alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 16-bit combinational AND/OR/ADD/SUB ALU.
- Adds width generalisation, a 3-bit opcode (XOR, shifts, multi-cycle multiply) and a full flag set.
- Uses valid/ready handshakes on input and output, with one operation in flight.
- Sits between the datapath register file and writeback.

Parameters:
- WIDTH, 16, operand/result width in bits; legal values are >= 4, powers of two.
- SHW, $clog2(WIDTH), derived width of the shift amount; not overridden.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- InValid  input  1  operands and Control are valid this cycle.
- InReady  output  1  block accepts an operation; transfer happens when InValid & InReady at a rising edge.
- Control  input  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; for shifts, only B[SHW-1:0] is the shift amount.
- OutValid  output  1  Result and flags are valid.
- OutReady  input  1  consumer takes the result; transfer happens when OutValid & OutReady at a rising edge.
- Result  output  WIDTH  registered result.
- CB  output  1  carry/borrow/shift-out/multiply-overflow flag.
- Z  output  1  Result == 0.
- N  output  1  Result[WIDTH-1].
- V  output  1  signed overflow.

Behaviour:
- Reset (asynchronous, any time, including mid-MUL):
  - State = IDLE; in-flight operation is discarded.
  - OutValid, Result, CB, Z, N, V all = 0.
  - InReady = 1 in the first cycle after Reset deasserts.
- States:
  - IDLE: no result held.
  - MUL: iterating a multiply.
  - HOLD: result held until consumed.
- InReady = (state==IDLE) | (state==HOLD & OutReady). Draining a result and accepting the next operation in the same cycle is legal. InReady = 0 in MUL.
- Single-cycle ops (000–110): accepted at edge N; Result and flags registered at edge N; OutValid = 1 after edge N; state -> HOLD.
- MUL:
  - Accept at edge N captures A, B and clears the accumulator and counter; state -> MUL.
  - Shift-add, one multiplier bit per cycle, LSB first.
  - At edge N+WIDTH the low WIDTH bits of the product load into Result; OutValid = 1; state -> HOLD.
- HOLD:
  - Result and flags stay stable while OutReady = 0.
  - On OutReady & ~InValid: -> IDLE, OutValid = 0.
  - On OutReady & InValid: the new operation is taken; next state follows its opcode.
- Arithmetic:
  - ADD: {CB,Result} = A + B.
  - SUB: {CB,Result} = A + ~B + 1, so CB = 1 means no borrow (A >= B unsigned).
  - V = signed overflow for ADD/SUB; V = 0 for all other ops.
- Logic ops: CB = 0.
- SHL/SHR:
  - Shift amount 0 -> Result = A, CB = 0.
  - Otherwise CB = the last bit shifted out.
- MUL: unsigned; CB = 1 if product bits [2*WIDTH-1:WIDTH] are nonzero.
- Z and N are always derived from the final Result, including a saturated Result.
- Inputs are sampled only at the accepting edge; changes at any other time have no effect.

Optional Feature:
- Macro: ALU_SAT_EN.
- When defined: ADD/SUB with signed overflow saturate.
  - Positive overflow -> Result = 0x7F..F.
  - Negative overflow -> Result = 0x80..0.
  - V = 1 and CB is computed as without saturation.
- When undefined: Result wraps modulo 2^WIDTH.
- No other op is affected in either case.

Test Plan:
- Reset with WIDTH=16 -> all outputs 0, InReady=1; assert Reset again mid-HOLD -> OutValid drops asynchronously, before the next edge.
- ADD A=0xFFFF, B=0x0001 -> one cycle after accept: Result=0x0000, CB=1, Z=1, N=0, V=0.
- SUB A=0x8000, B=0x0001:
  - Without ALU_SAT_EN -> Result=0x7FFF, CB=1, V=1, N=0.
  - With ALU_SAT_EN -> Result=0x8000, V=1, N=1.
- MUL A=0x0123, B=0x0010 -> InReady=0 for 16 cycles, then OutValid=1, Result=0x1230, CB=0. MUL 0x8000×0x0002 -> Result=0x0000, CB=1, Z=1.
- Backpressure:
  - SHR A=0x8001, B=0x0001 with OutReady=0 for 5 cycles -> Result=0x4000, CB=1, held stable; InReady=0.
  - Then OutReady=1 with InValid=1 (AND A=0x00FF, B=0x0F0F) -> drain and accept on the same edge; next Result=0x000F.
- Reset asserted at cycle 7 of a MUL -> OutValid=0, Result=0; after release, ADD 2+3 -> Result=0x0005, OutValid one cycle after accept.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on input and output.
// Opcodes: AND, OR, ADD, SUB, XOR, SHL, SHR (logical), MUL (shift-add, WIDTH cycles).
// Only one operation is in flight at a time.
// Optional build macro ALU_SAT_EN: signed-overflowing ADD/SUB saturate instead of wrapping.
module alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       Control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             CB,
    output logic             Z,
    output logic             N,
    output logic             V
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned PW  = 2 * WIDTH;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

`ifdef ALU_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [SHW-1:0]   r_cnt;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic             w_add_v;
    logic             w_sub_v;
    logic [SHW-1:0]   w_amt;
    logic [PW-1:0]    w_shl;
    logic [PW-1:0]    w_shr;
    logic [WIDTH-1:0] w_res;
    logic             w_cb;
    logic             w_v;
    logic [PW-1:0]    w_acc_nxt;

    // Accept when idle, or when the held result is being drained this same edge
    assign InReady  = (r_state == S_IDLE) | ((r_state == S_HOLD) & OutReady);
    assign w_accept = InValid & InReady;

    // Single-cycle datapath: result, carry/borrow/shift-out and overflow
    always_comb begin
        w_sum   = {1'b0, A} + {1'b0, B};
        w_dif   = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
        w_add_v = (A[WIDTH-1] == B[WIDTH-1]) & (w_sum[WIDTH-1] != A[WIDTH-1]);
        w_sub_v = (A[WIDTH-1] != B[WIDTH-1]) & (w_dif[WIDTH-1] != A[WIDTH-1]);
        w_amt   = B[SHW-1:0];
        // Shift in a double-width window so the last bit shifted out lands at a fixed position
        w_shl   = {WIDTH'(0), A} << w_amt;
        w_shr   = {A, WIDTH'(0)} >> w_amt;
        w_res   = '0;
        w_cb    = 1'b0;
        w_v     = 1'b0;
        case (Control)
            OP_AND: w_res = A & B;
            OP_OR:  w_res = A | B;
            OP_XOR: w_res = A ^ B;
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_cb  = w_sum[WIDTH];
                w_v   = w_add_v;
`ifdef ALU_SAT_EN
                if (w_add_v) w_res = A[WIDTH-1] ? MIN_NEG : MAX_POS;
`endif
            end
            OP_SUB: begin
                w_res = w_dif[WIDTH-1:0];
                w_cb  = w_dif[WIDTH];
                w_v   = w_sub_v;
`ifdef ALU_SAT_EN
                if (w_sub_v) w_res = A[WIDTH-1] ? MIN_NEG : MAX_POS;
`endif
            end
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_cb  = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[PW-1:WIDTH];
                w_cb  = w_shr[WIDTH-1];
            end
            default: begin
                w_res = '0;
                w_cb  = 1'b0;
                w_v   = 1'b0;
            end
        endcase
    end

    // One shift-add step of the multiply: add multiplicand when the current multiplier bit is set
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : PW'(0));

    // Control FSM, multiply iteration and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            OutValid <= 1'b0;
            Result   <= '0;
            CB       <= 1'b0;
            Z        <= 1'b0;
            N        <= 1'b0;
            V        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_accept) begin
                        if (Control == OP_MUL) begin
                            r_acc    <= '0;
                            r_mcand  <= {WIDTH'(0), A};
                            r_mplier <= B;
                            r_cnt    <= '0;
                            OutValid <= 1'b0;
                            r_state  <= S_MUL;
                        end else begin
                            Result   <= w_res;
                            CB       <= w_cb;
                            Z        <= (w_res == '0);
                            N        <= w_res[WIDTH-1];
                            V        <= w_v;
                            OutValid <= 1'b1;
                            r_state  <= S_HOLD;
                        end
                    end else if ((r_state == S_HOLD) && OutReady) begin
                        OutValid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + SHW'(1);
                    if (r_cnt == SHW'(WIDTH - 1)) begin
                        Result   <= w_acc_nxt[WIDTH-1:0];
                        CB       <= |w_acc_nxt[PW-1:WIDTH];
                        Z        <= (w_acc_nxt[WIDTH-1:0] == '0);
                        N        <= w_acc_nxt[WIDTH-1];
                        V        <= 1'b0;
                        OutValid <= 1'b1;
                        r_state  <= S_HOLD;
                    end
                end
                default: begin
                    OutValid <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven vectors for alu_seq (WIDTH=16) plus hand-written
// sequences for backpressure, same-edge drain/accept and asynchronous reset.
module tb_alu_seq;

    localparam int unsigned W = 16;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         InValid;
    logic         InReady;
    logic [2:0]   Control;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         OutValid;
    logic         OutReady;
    logic [W-1:0] Result;
    logic         CB;
    logic         Z;
    logic         N;
    logic         V;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cb;
        logic         z;
        logic         n;
        logic         v;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    alu_seq #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .Control  (Control),
        .A        (A),
        .B        (B),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Result   (Result),
        .CB       (CB),
        .Z        (Z),
        .N        (N),
        .V        (V)
    );

    always #5 Clk = ~Clk;

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Present one operation, wait (bounded) for acceptance, then set OutReady for the hold phase
    task automatic do_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic rdy_after);
        logic acc;
        acc      = 1'b0;
        Control  = c;
        A        = a;
        B        = b;
        InValid  = 1'b1;
        OutReady = 1'b1;
        for (int k = 0; k < 50; k++) begin
            #1;
            acc = InReady;
            @(posedge Clk);
            #1;
            if (acc) break;
        end
        InValid  = 1'b0;
        OutReady = rdy_after;
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout got=0 exp=1");
        end
    endtask

    // Bounded wait for a multiply result; checks busy latency and InReady low throughout
    task automatic wait_mul(input string tag);
        int cyc;
        int busy_ready;
        cyc        = 0;
        busy_ready = 0;
        while (!OutValid && cyc < 40) begin
            if (InReady) busy_ready++;
            @(posedge Clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(W));
        chk({tag, "_inready_busy"}, 32'(busy_ready), 32'd0);
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] res, input logic cb,
                           input logic z, input logic n, input logic v);
        chk({tag, "_valid"}, 32'(OutValid), 32'd1);
        chk({tag, "_result"}, 32'(Result), 32'(res));
        chk({tag, "_cb"}, 32'(CB), 32'(cb));
        chk({tag, "_z"}, 32'(Z), 32'(z));
        chk({tag, "_n"}, 32'(N), 32'(n));
        chk({tag, "_v"}, 32'(V), 32'(v));
    endtask

    initial begin
        //             ctrl    a         b         res       cb    z     n     v
        vecs[0]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef ALU_SAT_EN
        vecs[1]  = '{OP_SUB, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        vecs[1]  = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
        vecs[2]  = '{OP_AND, 16'h00FF, 16'h0F0F, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{OP_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{OP_XOR, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{OP_SHL, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{OP_SHR, 16'h8001, 16'h0001, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{OP_SHL, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{OP_MUL, 16'h0123, 16'h0010, 16'h1230, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{OP_MUL, 16'h8000, 16'h0002, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{OP_SHR, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{OP_SHL, 16'h0003, 16'h000F, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0};

        Reset    = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b0;
        Control  = 3'b000;
        A        = '0;
        B        = '0;

        // Reset state
        #1;
        chk("rst_outvalid", 32'(OutValid), 32'd0);
        chk("rst_result", 32'(Result), 32'd0);
        chk("rst_flags", 32'({CB, Z, N, V}), 32'd0);
        chk("rst_inready", 32'(InReady), 32'd1);
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        chk("post_rst_inready", 32'(InReady), 32'd1);
        chk("post_rst_outvalid", 32'(OutValid), 32'd0);

        // Vector table, back-to-back with OutReady=1 (drain and accept on the same edge)
        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, 1'b1);
            if (vecs[i].ctrl == OP_MUL) wait_mul($sformatf("v%0d", i));
            chk_out($sformatf("v%0d", i), vecs[i].res, vecs[i].cb, vecs[i].z, vecs[i].n, vecs[i].v);
        end
        @(posedge Clk);
        #1;
        chk("drain_idle_outvalid", 32'(OutValid), 32'd0);
        chk("drain_idle_inready", 32'(InReady), 32'd1);

        // Backpressure: result held stable, inputs ignored, InReady low
        do_op(OP_SHR, 16'h8001, 16'h0001, 1'b0);
        for (int k = 0; k < 5; k++) begin
            A       = 16'($urandom);
            B       = 16'($urandom);
            Control = 3'($urandom);
            @(posedge Clk);
            #1;
            chk($sformatf("bp%0d_result", k), 32'(Result), 32'h4000);
            chk($sformatf("bp%0d_cb", k), 32'(CB), 32'd1);
            chk($sformatf("bp%0d_valid", k), 32'(OutValid), 32'd1);
            chk($sformatf("bp%0d_inready", k), 32'(InReady), 32'd0);
        end

        // Drain and accept AND on the same edge
        Control  = OP_AND;
        A        = 16'h00FF;
        B        = 16'h0F0F;
        InValid  = 1'b1;
        OutReady = 1'b1;
        #1;
        chk("bp_release_inready", 32'(InReady), 32'd1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        chk_out("bp_and", 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        chk("bp_drain_outvalid", 32'(OutValid), 32'd0);

        // Asynchronous reset while holding a result
        do_op(OP_ADD, 16'h0001, 16'h0001, 1'b0);
        chk("hold_pre_rst_valid", 32'(OutValid), 32'd1);
        #3;
        Reset = 1'b1;
        #1;
        chk("hold_rst_async_valid", 32'(OutValid), 32'd0);
        chk("hold_rst_async_result", 32'(Result), 32'd0);
        #2;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        chk("hold_rst_after_inready", 32'(InReady), 32'd1);
        chk("hold_rst_after_valid", 32'(OutValid), 32'd0);

        // Asynchronous reset at cycle 7 of a MUL, then a fresh ADD
        do_op(OP_XOR, 16'hA5A5, 16'h0000, 1'b1);
        chk("pre_mul_result", 32'(Result), 32'hA5A5);
        do_op(OP_MUL, 16'h0123, 16'h0010, 1'b1);
        repeat (6) begin
            @(posedge Clk);
            #1;
        end
        chk("mul7_busy_valid", 32'(OutValid), 32'd0);
        chk("mul7_busy_inready", 32'(InReady), 32'd0);
        #2;
        Reset = 1'b1;
        #1;
        chk("mul_rst_valid", 32'(OutValid), 32'd0);
        chk("mul_rst_result", 32'(Result), 32'd0);
        chk("mul_rst_inready", 32'(InReady), 32'd1);
        #2;
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        do_op(OP_ADD, 16'h0002, 16'h0003, 1'b1);
        chk_out("post_mul_rst_add", 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
        // The aborted multiply must never deliver a result
        repeat (20) begin
            @(posedge Clk);
            #1;
        end
        chk("aborted_mul_no_valid", 32'(OutValid), 32'd0);
        chk("aborted_mul_result", 32'(Result), 32'h0005);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
